// File: rtl/multi_load_counter_if.sv
// multi_load_counter_if: per-channel control, load and status bundle for multi_load_counter.
// Carries status_clr/done_sticky only when MULTI_LOAD_COUNTER_STATUS_EN is defined.
interface multi_load_counter_if #(
  parameter int BIT_WIDTH = 16,
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] load_en, upordown, auto_reload, start, continue_1;
  logic [NUM_CH*BIT_WIDTH-1:0] load, count;
  logic [NUM_CH-1:0] pulse, busy;
`ifdef MULTI_LOAD_COUNTER_STATUS_EN
  logic [NUM_CH-1:0] status_clr, done_sticky;
  modport master(output load_en, load, upordown, auto_reload, start, continue_1, status_clr,
                 input count, pulse, busy, done_sticky);
  modport slave(input load_en, load, upordown, auto_reload, start, continue_1, status_clr,
                output count, pulse, busy, done_sticky);
`else
  modport master(output load_en, load, upordown, auto_reload, start, continue_1,
                 input count, pulse, busy);
  modport slave(input load_en, load, upordown, auto_reload, start, continue_1,
                output count, pulse, busy);
`endif
endinterface

// File: rtl/multi_load_counter.sv
// multi_load_counter: NUM_CH independent loadable up/down counters with one-shot/auto-reload terminal pulses.
// MULTI_LOAD_COUNTER_STATUS_EN adds per-channel sticky done flags cleared by status_clr.
module multi_load_counter #(
  parameter int BIT_WIDTH = 16,
  parameter int NUM_CH = 4
) (
  input logic clk,
  input logic reset,
  multi_load_counter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t state, state_nxt;
    logic [BIT_WIDTH-1:0] cnt, rld, cnt_nxt, ld, term;
    logic pls, pls_nxt, at_term, step_en;
    assign ld = bus.load[i*BIT_WIDTH +: BIT_WIDTH];
    assign term = bus.upordown[i] ? '1 : '0;
    assign at_term = cnt == term;
    // a step happens only in RUN with no load, stop or pause request this edge
    assign step_en = !bus.load_en[i] && bus.start[i] && bus.continue_1[i] && state == RUN;
    always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_nxt;
    always_comb
      state_nxt = bus.load_en[i] ? (state == DONE ? IDLE : state)
                : !bus.start[i] ? IDLE
                : state == DONE ? DONE
                : !bus.continue_1[i] ? PAUSE
                : state == RUN && at_term && !bus.auto_reload[i] ? DONE : RUN;
    always_comb begin
      cnt_nxt = bus.load_en[i] ? ld
              : !step_en ? cnt
              : !at_term ? (bus.upordown[i] ? cnt + BIT_WIDTH'(1) : cnt - BIT_WIDTH'(1))
              : bus.auto_reload[i] ? rld : cnt;
      pls_nxt = step_en && at_term;
    end
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        cnt <= '0;
        rld <= '0;
        pls <= 1'b0;
      end else begin
        cnt <= cnt_nxt;
        rld <= bus.load_en[i] ? ld : rld;
        pls <= pls_nxt;
      end
    assign bus.count[i*BIT_WIDTH +: BIT_WIDTH] = cnt;
    assign bus.pulse[i] = pls;
    assign bus.busy[i] = state == RUN || state == PAUSE;
  end
`ifdef MULTI_LOAD_COUNTER_STATUS_EN
  // set has priority over a coincident clear
  always_ff @(posedge clk or posedge reset)
    if (reset) bus.done_sticky <= '0;
    else bus.done_sticky <= bus.pulse | (bus.done_sticky & ~bus.status_clr);
`endif
endmodule

// File: tb/tb_multi_load_counter.sv
// tb_multi_load_counter: directed plus random stimulus, reference model feeds a scoreboard queue
// that a separate monitor drains every cycle.
module tb_multi_load_counter;
  localparam int W = 8;
  localparam int NC = 4;
  localparam int MAXV = (1 << W) - 1;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  multi_load_counter_if #(.BIT_WIDTH(W), .NUM_CH(NC)) bus();
  multi_load_counter #(.BIT_WIDTH(W), .NUM_CH(NC)) dut(.clk(clk), .reset(reset), .bus(bus));
  typedef struct packed {
    logic [NC*W-1:0] cnt;
    logic [NC-1:0] pls;
    logic [NC-1:0] bsy;
    logic [NC-1:0] stk;
  } exp_t;
  exp_t sb[$];
  int m_cnt[NC], m_rld[NC], m_mode[NC];
  bit m_pls[NC], m_stk[NC];
  int n_chk = 0, n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Apply the rules for the upcoming rising edge to the model, using the inputs now driven.
  task automatic predict();
    exp_t e;
    for (int c = 0; c < NC; c++) begin
      int ld, term;
      bit clr;
      ld = int'(bus.load[c*W +: W]);
      term = bus.upordown[c] ? MAXV : 0;
      clr = 1'b0;
`ifdef MULTI_LOAD_COUNTER_STATUS_EN
      clr = bus.status_clr[c];
`endif
      if (reset) begin
        m_cnt[c] = 0; m_rld[c] = 0; m_mode[c] = M_IDLE; m_pls[c] = 0; m_stk[c] = 0;
      end else begin
        m_stk[c] = m_pls[c] || (m_stk[c] && !clr);
        m_pls[c] = 0;
        if (bus.load_en[c]) begin
          m_cnt[c] = ld;
          m_rld[c] = ld;
          if (m_mode[c] == M_DONE) m_mode[c] = M_IDLE;
        end else if (!bus.start[c]) m_mode[c] = M_IDLE;
        else if (m_mode[c] == M_IDLE || m_mode[c] == M_PAUSE)
          m_mode[c] = bus.continue_1[c] ? M_RUN : M_PAUSE;
        else if (m_mode[c] == M_RUN) begin
          if (!bus.continue_1[c]) m_mode[c] = M_PAUSE;
          else if (m_cnt[c] == term) begin
            m_pls[c] = 1;
            if (bus.auto_reload[c]) m_cnt[c] = m_rld[c];
            else m_mode[c] = M_DONE;
          end else m_cnt[c] = bus.upordown[c] ? (m_cnt[c] + 1) % (MAXV + 1)
                                              : (m_cnt[c] + MAXV) % (MAXV + 1);
        end
      end
      e.cnt[c*W +: W] = W'(m_cnt[c]);
      e.pls[c] = m_pls[c];
      e.bsy[c] = m_mode[c] == M_RUN || m_mode[c] == M_PAUSE;
      e.stk[c] = m_stk[c];
    end
    sb.push_back(e);
  endtask

  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("count", 64'(bus.count), 64'(e.cnt));
      check("pulse", 64'(bus.pulse), 64'(e.pls));
      check("busy", 64'(bus.busy), 64'(e.bsy));
`ifdef MULTI_LOAD_COUNTER_STATUS_EN
      check("done_sticky", 64'(bus.done_sticky), 64'(e.stk));
`endif
    end
  end

  initial begin
    bit ld3, paused;
    int pause_left;
    reset = 1'b1;
    bus.load_en = '0;
    bus.load = '0;
    bus.upordown = '1;
    bus.auto_reload = '0;
    bus.start = '1;
    bus.continue_1 = '1;
`ifdef MULTI_LOAD_COUNTER_STATUS_EN
    bus.status_clr = '0;
`endif
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      predict();
    end
    // load all channels with start low, then run the directed scenario
    @(negedge clk);
    reset = 1'b0;
    bus.load_en = '1;
    bus.load = {W'(200), W'(10), W'(5), W'(100)};
    bus.upordown = 4'b1101;
    bus.auto_reload = 4'b0010;
    bus.start = '0;
    predict();
    ld3 = 0; paused = 0; pause_left = 0;
    for (int n = 0; n < 320; n++) begin
      @(negedge clk);
      bus.load_en = '0;
      bus.start = '1;
      if (n >= 120) bus.start[2] = 1'b0;
      if (!paused && m_mode[2] == M_RUN && m_cnt[2] == 20) begin
        paused = 1;
        pause_left = 10;
      end
      bus.continue_1[2] = pause_left == 0;
      if (pause_left > 0) pause_left--;
      if (!ld3 && m_mode[3] == M_RUN && m_cnt[3] == MAXV) begin
        ld3 = 1;
        bus.load_en[3] = 1'b1;
        bus.load[3*W +: W] = W'(7);
      end
`ifdef MULTI_LOAD_COUNTER_STATUS_EN
      bus.status_clr[1] = (n < 150) ? m_pls[1] : (n % 17 == 0);
`endif
      predict();
    end
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      reset = $urandom_range(0, 399) == 0;
      for (int c = 0; c < NC; c++) begin
        int sel;
        sel = $urandom_range(0, 3);
        bus.load_en[c] = $urandom_range(0, 15) == 0;
        bus.load[c*W +: W] = sel == 0 ? W'(0) : sel == 1 ? W'(MAXV) : W'($urandom_range(0, MAXV));
        if ($urandom_range(0, 31) == 0) bus.upordown[c] = ~bus.upordown[c];
        if ($urandom_range(0, 31) == 0) bus.auto_reload[c] = ~bus.auto_reload[c];
        if ($urandom_range(0, 39) == 0) bus.start[c] = ~bus.start[c];
        bus.continue_1[c] = $urandom_range(0, 7) != 0;
`ifdef MULTI_LOAD_COUNTER_STATUS_EN
        bus.status_clr[c] = $urandom_range(0, 7) == 0;
`endif
      end
      predict();
    end
    repeat (3) @(posedge clk);
    #2;
    check("drain", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
